// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache control path.
// Holds the controller state encoding and the default block size.
package cache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'b00;
    localparam state_t ST_REFILL = 2'b01;
    localparam state_t ST_WRITE  = 2'b10;

    localparam int unsigned WPB_DEFAULT = 4;

endpackage

// File: rtl/refill_counter.sv
// Word-offset counter for block refills, modulo WORDS_PER_BLOCK.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-low reset, forces CNT to 0
//   CLR  - forces CNT to 0 (used whenever no refill is in progress)
//   INC  - advance by one word, wrapping after the last word
//   CNT  - current word offset
//   LAST - CNT is the final word of the block
module refill_counter #(
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             INC,
    output logic [IDX_W-1:0] CNT,
    output logic             LAST
);

    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    assign LAST = (cnt_q == IDX_W'(WORDS_PER_BLOCK - 1));
    assign CNT  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (INC) begin
            cnt_d = LAST ? '0 : cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Control FSM for a direct-mapped, write-through, no-write-allocate data cache.
// Ports:
//   CLK, RST          - clock and synchronous active-low reset
//   MEM_RD_REQ/WR_REQ - CPU load/store requests, held while STALL is high
//   HIT               - combinational tag-compare result for the current address
//   MEM_READY         - main-memory pulse: read word valid / write accepted
//   STALL             - freezes the CPU pipeline
//   MAIN_RD/MAIN_WR   - main-memory read/write requests
//   CACHE_WE, TAG_WE  - data-array word write and tag/valid write
//   REFILL_IDX        - word offset of the refill word
//   DATA_SEL          - data-array write mux: 0 = CPU store data, 1 = memory data
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = WPB_DEFAULT,
    parameter int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MEM_RD_REQ,
    input  logic             MEM_WR_REQ,
    input  logic             HIT,
    input  logic             MEM_READY,
    output logic             STALL,
    output logic             MAIN_RD,
    output logic             MAIN_WR,
    output logic             CACHE_WE,
    output logic             TAG_WE,
    output logic [IDX_W-1:0] REFILL_IDX,
    output logic             DATA_SEL
);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] cnt;
    logic             cnt_last;
    logic             cnt_clr;
    logic             cnt_inc;

    assign cnt_clr = (state_q != ST_REFILL);
    assign cnt_inc = (state_q == ST_REFILL) && MEM_READY;

    refill_counter #(
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .IDX_W           (IDX_W)
    ) u_refill_counter (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (cnt_clr),
        .INC  (cnt_inc),
        .CNT  (cnt),
        .LAST (cnt_last)
    );

    // Outputs are gated by RST so everything reads 0 while reset is held,
    // even before the first clock edge has cleared the state.
    always_comb begin
        state_d    = state_q;
        STALL      = 1'b0;
        MAIN_RD    = 1'b0;
        MAIN_WR    = 1'b0;
        CACHE_WE   = 1'b0;
        TAG_WE     = 1'b0;
        DATA_SEL   = 1'b0;
        REFILL_IDX = '0;
        if (RST) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Stores win over loads when both are requested.
                    if (MEM_WR_REQ) begin
                        STALL   = 1'b1;
                        state_d = ST_WRITE;
                    end else if (MEM_RD_REQ && !HIT) begin
                        STALL   = 1'b1;
                        state_d = ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    STALL      = 1'b1;
                    MAIN_RD    = 1'b1;
                    DATA_SEL   = 1'b1;
                    REFILL_IDX = cnt;
                    if (MEM_READY) begin
                        CACHE_WE = 1'b1;
                        if (cnt_last) begin
                            TAG_WE  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    MAIN_WR = 1'b1;
                    STALL   = !MEM_READY;
                    if (MEM_READY) begin
                        // No allocate on a store miss.
                        CACHE_WE = HIT;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller against a transaction-level model.
module tb_cache_controller;

    localparam int unsigned W     = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned OW    = 6 + IDX_W;

    logic             clk;
    logic             rst_n;
    logic             rd_req;
    logic             wr_req;
    logic             hit;
    logic             ready;
    logic             stall;
    logic             main_rd;
    logic             main_wr;
    logic             cache_we;
    logic             tag_we;
    logic [IDX_W-1:0] refill_idx;
    logic             data_sel;

    int checks = 0;
    int passes = 0;

    // Model: words still to arrive for the current refill (0 = none),
    // and whether a write-through is outstanding.
    int m_left  = 0;
    bit m_write = 1'b0;

    cache_controller #(
        .WORDS_PER_BLOCK (W),
        .IDX_W           (IDX_W)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .MEM_RD_REQ (rd_req),
        .MEM_WR_REQ (wr_req),
        .HIT        (hit),
        .MEM_READY  (ready),
        .STALL      (stall),
        .MAIN_RD    (main_rd),
        .MAIN_WR    (main_wr),
        .CACHE_WE   (cache_we),
        .TAG_WE     (tag_we),
        .REFILL_IDX (refill_idx),
        .DATA_SEL   (data_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector layout: {stall, main_rd, main_wr, cache_we, tag_we, data_sel, idx}
    // Drives one cycle, samples DUT at negedge, returns model expectation,
    // and advances the model at the following posedge.
    task automatic tick(input logic r, input logic rd, input logic wr, input logic h,
                        input logic rdy, output logic [OW-1:0] obs,
                        output logic [OW-1:0] exp);
        logic             e_stall, e_rd, e_wr, e_we, e_tag, e_sel;
        logic [IDX_W-1:0] e_idx;
        int               n_left;
        bit               n_write;
        rst_n = r; rd_req = rd; wr_req = wr; hit = h; ready = rdy;
        @(negedge clk);
        obs = {stall, main_rd, main_wr, cache_we, tag_we, data_sel, refill_idx};
        {e_stall, e_rd, e_wr, e_we, e_tag, e_sel} = 6'b0;
        e_idx   = '0;
        n_left  = m_left;
        n_write = m_write;
        if (!r) begin
            n_left  = 0;
            n_write = 1'b0;
        end else if (m_left > 0) begin
            e_stall = 1'b1; e_rd = 1'b1; e_sel = 1'b1;
            e_idx   = IDX_W'(W - m_left);
            e_we    = rdy;
            e_tag   = rdy && (m_left == 1);
            if (rdy) n_left = m_left - 1;
        end else if (m_write) begin
            e_wr    = 1'b1;
            e_stall = !rdy;
            e_we    = rdy && h;
            if (rdy) n_write = 1'b0;
        end else if (wr) begin
            e_stall = 1'b1;
            n_write = 1'b1;
        end else if (rd && !h) begin
            e_stall = 1'b1;
            n_left  = W;
        end
        exp = {e_stall, e_rd, e_wr, e_we, e_tag, e_sel, e_idx};
        @(posedge clk);
        m_left  = n_left;
        m_write = n_write;
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] obs, exp;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, obs, exp);
            checks++;
            if (obs !== exp || obs !== '0) begin
                $display("FAIL reset: got %h want %h", obs, exp);
            end else passes++;
        end
    endtask

    task automatic test_read_hit();
        logic [OW-1:0] obs, exp;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1, i[0], obs, exp);
            checks++;
            if (obs !== exp || obs[OW-1] !== 1'b0) begin
                $display("FAIL read_hit cyc%0d: got %h want %h", i, obs, exp);
            end else passes++;
        end
    endtask

    // Miss with MEM_READY every gap-th REFILL cycle.
    task automatic run_miss(input int gap, input string name);
        logic [OW-1:0] obs, exp;
        int stall_cnt = 0, we_cnt = 0, tag_cnt = 0, cyc = 0, phase = 0;
        bit idx_ok = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, obs, exp);
        if (obs[OW-1]) stall_cnt++;
        checks++;
        if (obs !== exp) $display("FAIL %s detect: got %h want %h", name, obs, exp);
        else passes++;
        while (m_left > 0 && cyc < 100) begin
            phase++;
            tick(1'b1, 1'b1, 1'b0, 1'b0, (phase % gap) == 0, obs, exp);
            cyc++;
            if (obs[OW-1]) stall_cnt++;
            if (obs[OW-4]) begin
                if (obs[IDX_W-1:0] !== IDX_W'(we_cnt) || obs[OW-6] !== 1'b1) idx_ok = 1'b0;
                we_cnt++;
            end
            if (obs[OW-5]) tag_cnt++;
            checks++;
            if (obs !== exp) $display("FAIL %s refill cyc%0d: got %h want %h", name, cyc, obs, exp);
            else passes++;
        end
        checks++;
        if (stall_cnt != 1 + gap * W) begin
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, 1 + gap * W);
        end else passes++;
        checks++;
        if (we_cnt != W || !idx_ok) begin
            $display("FAIL %s we_pulses: got %0d (idx_ok=%0d) want %0d", name, we_cnt, idx_ok, W);
        end else passes++;
        checks++;
        if (tag_cnt != 1) $display("FAIL %s tag_we_pulses: got %0d want 1", name, tag_cnt);
        else passes++;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, obs, exp);
        checks++;
        if (obs !== exp || obs[OW-1] !== 1'b0) begin
            $display("FAIL %s retry_hit: got %h want %h", name, obs, exp);
        end else passes++;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, obs, exp);
    endtask

    task automatic test_read_miss();
        run_miss(1, "miss_fast");
    endtask

    task automatic test_read_miss_slow();
        run_miss(3, "miss_slow");
    endtask

    task automatic test_store();
        logic [OW-1:0] obs, exp;
        for (int h = 1; h >= 0; h--) begin
            int wr_cnt = 0, we_cnt = 0, stall_cnt = 0;
            bit sel_ok = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick(1'b1, 1'b0, 1'b1, h[0], c == 2, obs, exp);
                if (obs[OW-3]) wr_cnt++;
                if (obs[OW-4]) we_cnt++;
                if (obs[OW-1]) stall_cnt++;
                if (obs[OW-4] && obs[OW-6]) sel_ok = 1'b0;
                checks++;
                if (obs !== exp) $display("FAIL store h%0d cyc%0d: got %h want %h", h, c, obs, exp);
                else passes++;
            end
            checks++;
            if (wr_cnt != 2 || we_cnt != h || stall_cnt != 2 || !sel_ok) begin
                $display("FAIL store_summary h%0d: got wr=%0d we=%0d stall=%0d want wr=2 we=%0d stall=2",
                         h, wr_cnt, we_cnt, stall_cnt, h);
            end else passes++;
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, obs, exp);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [OW-1:0] obs, exp;
        int tag_cnt = 0;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, obs, exp);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, obs, exp);
        if (obs[OW-5]) tag_cnt++;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, obs, exp);
        if (obs[OW-5]) tag_cnt++;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, obs, exp);
        checks++;
        if (obs !== '0 || obs !== exp) $display("FAIL rst_mid held: got %h want %h", obs, exp);
        else passes++;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, obs, exp);
        checks++;
        if (obs !== '0 || obs !== exp) $display("FAIL rst_mid idle: got %h want %h", obs, exp);
        else passes++;
        checks++;
        if (tag_cnt != 0) $display("FAIL rst_mid tag_we: got %0d want 0", tag_cnt);
        else passes++;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, obs, exp);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, obs, exp);
        checks++;
        if (obs !== exp || obs[IDX_W-1:0] !== '0 || obs[OW-4] !== 1'b1) begin
            $display("FAIL rst_mid restart_idx: got %h want %h", obs, exp);
        end else passes++;
        // Flush the restarted refill.
        for (int i = 0; i < W - 1; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, obs, exp);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, obs, exp);
    endtask

    task automatic test_priority_stray();
        logic [OW-1:0] obs, exp;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, obs, exp);
        checks++;
        if (obs !== '0 || obs !== exp) $display("FAIL stray_ready: got %h want %h", obs, exp);
        else passes++;
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, obs, exp);
        checks++;
        if (obs !== exp) $display("FAIL both_req detect: got %h want %h", obs, exp);
        else passes++;
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, obs, exp);
        checks++;
        if (obs !== exp || obs[OW-2] !== 1'b0 || obs[OW-3] !== 1'b1) begin
            $display("FAIL both_req write: got %h want %h", obs, exp);
        end else passes++;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, obs, exp);
    endtask

    task automatic test_random();
        logic [OW-1:0] obs, exp;
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 39) != 0, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), obs, exp);
            checks++;
            if (obs !== exp) begin
                errs++;
                if (errs <= 10) $display("FAIL random cyc%0d: got %h want %h", i, obs, exp);
            end else passes++;
        end
    endtask

    initial begin
        rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; hit = 1'b0; ready = 1'b0;
        test_reset();
        test_read_hit();
        test_read_miss();
        test_read_miss_slow();
        test_store();
        test_reset_mid_refill();
        test_priority_stray();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Control FSM for the direct-mapped, write-through, no-write-allocate data cache in the RISC-V core. It takes CPU load/store requests and the tag-compare hit signal, and stalls the pipeline on misses and stores. It sequences multi-word block refills and write-through transfers to main memory over a ready handshake. It also drives DATA_SEL, the select of the 32-bit 2:1 mux that feeds the cache data array write port: IN0 is CPU store data, IN1 is main-memory read data.

## Interface
- WORDS_PER_BLOCK, 4: words per cache block; power of two, 2–16.
- IDX_W, $clog2(WORDS_PER_BLOCK): width of REFILL_IDX.

- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- MEM_RD_REQ  in  1  CPU load request, held until STALL is low.
- MEM_WR_REQ  in  1  CPU store request, held until STALL is low.
- HIT  in  1  valid & tag match for the current address; combinational, from the tag array.
- MEM_READY  in  1  one-cycle pulse from main memory: a read word is valid, or a write is accepted.
- STALL  out  1  freezes the CPU pipeline.
- MAIN_RD  out  1  main-memory read request.
- MAIN_WR  out  1  main-memory write request.
- CACHE_WE  out  1  write-enable for the data array, one word.
- TAG_WE  out  1  write tag and set valid for the current index.
- REFILL_IDX  out  IDX_W  word offset of the refill word, used as the low address bits to memory and to the data array.
- DATA_SEL  out  1  data-array write mux select: 0 = CPU store data, 1 = memory data.

## Operation
- States: IDLE, REFILL, WRITE.
- IDLE
  - MEM_WR_REQ: STALL=1 (Mealy), next state WRITE. Stores take priority when MEM_RD_REQ is also high.
  - MEM_RD_REQ & !HIT: STALL=1 (Mealy), next state REFILL.
  - MEM_RD_REQ & HIT: STALL=0; the load completes from the array.
  - No request: all outputs 0.
  - MEM_READY is ignored.
- REFILL
  - MAIN_RD=1, DATA_SEL=1, STALL=1.
  - On each MEM_READY: CACHE_WE=1 at the current REFILL_IDX, then the counter increments.
  - On MEM_READY with counter == WORDS_PER_BLOCK-1: TAG_WE=1 as well, counter wraps to 0, next state IDLE. The retried load then hits.
  - HIT is ignored in this state.
- WRITE
  - MAIN_WR=1, DATA_SEL=0.
  - STALL=1 until MEM_READY.
  - On MEM_READY: STALL=0 (Mealy), CACHE_WE=HIT (update on hit only; no allocate on miss), next state IDLE.
- Counter
  - Modulo WORDS_PER_BLOCK.
  - Advances only on MEM_READY in REFILL.
  - Otherwise holds 0.
- Reset
  - RST low at a clock edge forces IDLE and counter 0 from any state, including mid-refill.
  - While RST is low, all outputs are 0, including STALL.
  - A partially refilled block is never marked valid, because TAG_WE never fired.

## Timing
- Reset values: STALL=0, MAIN_RD=0, MAIN_WR=0, CACHE_WE=0, TAG_WE=0, DATA_SEL=0, REFILL_IDX=0.
- State and counter are registered.
- STALL, CACHE_WE and TAG_WE are combinational from state and inputs, with no added latency.
- Read hit: zero stall cycles.
- Read miss with MEM_READY every cycle: STALL high for WORDS_PER_BLOCK+1 cycles (5 at the default). The load completes in the following IDLE cycle.
- Store with MEM_READY on the first WRITE cycle: 1 stall cycle (the IDLE detect cycle).
- MEM_READY gaps stretch REFILL and WRITE indefinitely. No timeout.
- No request is accepted in REFILL or WRITE. The CPU holds its request under STALL.

## Structure
- Shared package cache_pkg holds:
  - state encoding: IDLE=2'b00, REFILL=2'b01, WRITE=2'b10;
  - the WORDS_PER_BLOCK default.
- Sub-module refill_counter (parameter WORDS_PER_BLOCK; inputs CLK, RST, CLR, INC; outputs CNT, LAST) holds the wrap logic.
- The FSM and output decode stay in cache_controller.

## Test plan
- Read hit: RST high, MEM_RD_REQ=1, HIT=1 → STALL=0, MAIN_RD=0, CACHE_WE=0 on every cycle.
- Read miss, 4 words, MEM_READY every cycle:
  - STALL high exactly 5 cycles.
  - CACHE_WE pulses with REFILL_IDX 0,1,2,3 and DATA_SEL=1.
  - TAG_WE on the fourth pulse only.
  - Then HIT=1 gives STALL=0.
- Read miss with MEM_READY every third cycle: REFILL_IDX advances only on pulses, and STALL is high for 1+3×4=13 cycles.
- Store hit, then store miss, with MEM_READY two cycles into WRITE:
  - Hit: MAIN_WR high for 2 cycles and one CACHE_WE pulse with DATA_SEL=0.
  - Miss: CACHE_WE stays 0.
- Reset mid-refill: RST low after the second MEM_READY → next cycle IDLE, all outputs 0, TAG_WE never asserted. After release, a miss restarts at REFILL_IDX=0.
- MEM_RD_REQ and MEM_WR_REQ both high in IDLE → WRITE entered and MAIN_RD stays 0. A stray MEM_READY in IDLE causes no output change.
